dmem_access_ctrl: RTL and testbench

Two-port access controller in front of the single-port word-addressed data memory. Arbitrates between the core load/store port (port 0) and the program/data loader port (port 1), converts byte addresses to word addresses, and performs byte/halfword loads (with sign/zero extension) and sub-word stores via single-cycle read-modify-write. Owns the memory's `wr_en`, `address` and `wr_data` pins; the memory's combinational `rd_data` returns to it.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_lane_unit.sv | 52 +++++
 rtl/dmem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory access controller:
//   - size_e  : access size encoding carried on p_size0 / p_size1
//   - state_e : controller FSM states
//   - LANE_MASK_* : right-aligned lane masks used for extraction and merging
//   - access_misaligned() : alignment rule for a given size and low address bits
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'b00,
      SZ_HALF    = 2'b01,
      SZ_WORD    = 2'b10,
      SZ_ILLEGAL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
   localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
   localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

   // Halves must sit on even bytes, words on multiples of four.
   function automatic logic access_misaligned(input size_e size, input logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      if (size == SZ_HALF && lane[0])        mis = 1'b1;
      if (size == SZ_WORD && lane != 2'b00)  mis = 1'b1;
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// -----------------------------------------------------------------------------
// dmem_lane_unit
// Purely combinational byte-lane datapath.
//   i_size       : access size (byte / half / word)
//   i_unsigned   : zero-extend loads when 1, sign-extend when 0
//   i_lane       : byte address bits [1:0]
//   i_wdata      : right-aligned store data
//   i_mem_word   : current memory word (read data)
//   o_load_data  : selected lane, extended to 32 bits
//   o_merged     : i_mem_word with the store lane replaced by i_wdata
// -----------------------------------------------------------------------------
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  size_e       i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_mem_word,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic [4:0]  w_shift;
   logic [31:0] w_shifted;
   logic [31:0] w_mask;

   assign w_shift   = {i_lane, 3'b000};
   assign w_shifted = i_mem_word >> w_shift;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      o_load_data = w_shifted;
      w_mask      = LANE_MASK_WORD;
      case (i_size)
         SZ_BYTE: begin
            w_mask      = LANE_MASK_BYTE;
            o_load_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
         end
         SZ_HALF: begin
            w_mask      = LANE_MASK_HALF;
            o_load_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         end
         default: ;
      endcase
   end

   // Clear the target lane, then drop the masked store data into it.
   assign o_merged = (i_mem_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Two-port access controller in front of a single-port word-addressed memory.
// Port 0 is the core, port 1 the loader; round-robin arbitration, one access
// every three cycles (accept / access / respond).
//   clk, rst              : clock, asynchronous active-low reset
//   p_valid/p_ready[1:0]  : per-port request handshake (ready only in IDLE)
//   p_we, p_size0/1, p_unsigned, p_addr0/1, p_wdata0/1 : request fields
//   r_valid[1:0]          : one-cycle response pulse to the owning port
//   r_err, r_rdata        : response status and extended load data
//   mem_wr_en, mem_addr, mem_wr_data, mem_rd_data : memory pins
// -----------------------------------------------------------------------------
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            p_valid,
   output logic [1:0]            p_ready,
   input  logic [1:0]            p_we,
   input  logic [1:0]            p_size0,
   input  logic [1:0]            p_size1,
   input  logic [1:0]            p_unsigned,
   input  logic [31:0]           p_addr0,
   input  logic [31:0]           p_addr1,
   input  logic [31:0]           p_wdata0,
   input  logic [31:0]           p_wdata1,
   output logic [1:0]            r_valid,
   output logic                  r_err,
   output logic [31:0]           r_rdata,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wr_data,
   input  logic [31:0]           mem_rd_data
);

   state_e      r_state;
   state_e      w_next_state;
   logic        r_last_grant;
   logic        r_gnt;
   logic        r_we;
   size_e       r_size;
   logic        r_uns;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_gnt_idx;
   logic        w_any_valid;
   logic        w_err;
   logic        w_access_ok;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   // ---------------------------------------------------------------- arbiter
   // On a tie the port that did not win last time gets the grant.
   assign w_any_valid = |p_valid;
   assign w_gnt_idx   = (p_valid == 2'b11) ? ~r_last_grant : p_valid[1];

   // ------------------------------------------------------------ FSM (comb)
   always_comb begin
      w_next_state = r_state;
      p_ready      = 2'b00;
      case (r_state)
         ST_IDLE: begin
            if (w_any_valid) begin
               p_ready[w_gnt_idx] = 1'b1;
               w_next_state       = ST_ACCESS;
            end
         end
         ST_ACCESS: w_next_state = ST_RESP;
         ST_RESP:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------ error check
   // Any address bit above the word-address range makes the access illegal.
   assign w_err = access_misaligned(r_size, r_addr[1:0])
                | (r_size == SZ_ILLEGAL)
                | ((r_addr >> (ADDR_WIDTH + 2)) != 32'd0);

   assign w_access_ok = (r_state == ST_ACCESS) && !w_err;

   dmem_lane_unit u_lane (
      .i_size      (r_size),
      .i_unsigned  (r_uns),
      .i_lane      (r_addr[1:0]),
      .i_wdata     (r_wdata),
      .i_mem_word  (mem_rd_data),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   // Memory pins come only from state and latched fields. The address is
   // allowed to sit at the last latched value outside ACCESS.
   assign mem_addr    = r_addr[ADDR_WIDTH+1:2];
   assign mem_wr_en   = w_access_ok && r_we;
   assign mem_wr_data = !mem_wr_en          ? 32'd0   :
                        (r_size == SZ_WORD) ? r_wdata : w_merged;

   // ------------------------------------------------------------ registers
   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_gnt        <= 1'b0;
         r_we         <= 1'b0;
         r_size       <= SZ_BYTE;
         r_uns        <= 1'b0;
         r_addr       <= 32'd0;
         r_wdata      <= 32'd0;
         r_valid      <= 2'b00;
         r_err        <= 1'b0;
         r_rdata      <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_valid <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (w_any_valid) begin
                  r_gnt        <= w_gnt_idx;
                  r_last_grant <= w_gnt_idx;
                  r_we         <= p_we[w_gnt_idx];
                  r_size       <= size_e'(w_gnt_idx ? p_size1 : p_size0);
                  r_uns        <= p_unsigned[w_gnt_idx];
                  r_addr       <= w_gnt_idx ? p_addr1  : p_addr0;
                  r_wdata      <= w_gnt_idx ? p_wdata1 : p_wdata0;
               end
            end
            ST_ACCESS: begin
               // Response registers update here so they are valid throughout RESP.
               r_valid <= r_gnt ? 2'b10 : 2'b01;
               r_err   <= w_err;
               r_rdata <= (w_err || r_we) ? 32'd0 : w_load_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Directed bench with a response scoreboard. Stimulus pushes the expected
// response (and expected memory write, if any) into queues; a monitor pops and
// compares whenever the DUT shows r_valid or mem_wr_en.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

   localparam int AW = 10;

   typedef struct {
      logic [1:0]  port_oh;
      logic        err;
      logic [31:0] rdata;
      int          acc_cyc;
   } rsp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    p_valid;
   logic [1:0]    p_ready;
   logic [1:0]    p_we;
   logic [1:0]    p_size0, p_size1;
   logic [1:0]    p_unsigned;
   logic [31:0]   p_addr0, p_addr1, p_wdata0, p_wdata1;
   logic [1:0]    r_valid;
   logic          r_err;
   logic [31:0]   r_rdata;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wr_data;
   logic [31:0]   mem_rd_data;

   logic [31:0]   mem [0:(1<<AW)-1];

   rsp_t rq[$];
   wr_t  wq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: combinational read, synchronous write.
   assign mem_rd_data = mem[mem_addr];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

   dmem_access_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .p_valid     (p_valid),
      .p_ready     (p_ready),
      .p_we        (p_we),
      .p_size0     (p_size0),
      .p_size1     (p_size1),
      .p_unsigned  (p_unsigned),
      .p_addr0     (p_addr0),
      .p_addr1     (p_addr1),
      .p_wdata0    (p_wdata0),
      .p_wdata1    (p_wdata1),
      .r_valid     (r_valid),
      .r_err       (r_err),
      .r_rdata     (r_rdata),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------ monitor
   always @(negedge clk) begin
      if (rst) begin
         if (p_ready != 2'b00)
            check("p_ready_not_both", {31'd0, p_ready == 2'b11}, 32'd0);
         if (mem_wr_en) begin
            if (wq.size() == 0) begin
               check("unexpected_write", {22'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
               wr_t w;
               w = wq.pop_front();
               check("wr_addr", {22'd0, mem_addr}, {22'd0, w.addr});
               check("wr_data", mem_wr_data, w.data);
            end
         end
         if (r_valid != 2'b00) begin
            if (rq.size() == 0) begin
               check("unexpected_resp", {30'd0, r_valid}, 32'd0);
            end else begin
               rsp_t e;
               e = rq.pop_front();
               check("resp_port",    {30'd0, r_valid}, {30'd0, e.port_oh});
               check("resp_err",     {31'd0, r_err},   {31'd0, e.err});
               check("resp_rdata",   r_rdata,          e.rdata);
               check("resp_latency", cyc,              e.acc_cyc + 2);
            end
         end
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic set_req(input int port, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      p_we[port]       = we;
      p_unsigned[port] = uns;
      if (port == 0) begin
         p_size0 = size; p_addr0 = addr; p_wdata0 = wdata;
      end else begin
         p_size1 = size; p_addr1 = addr; p_wdata1 = wdata;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (rq.size() != 0 || wq.size() != 0) begin
         check("drain_timeout", rq.size() + wq.size(), 32'd0);
         rq.delete();
         wq.delete();
      end
   endtask

   task automatic issue(input int port, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [31:0] exp_wdata);
      rsp_t e;
      wr_t  w;
      int   n;
      @(negedge clk);
      set_req(port, we, size, uns, addr, wdata);
      p_valid[port] = 1'b1;
      n = 0;
      #1;
      while (!p_ready[port] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!p_ready[port]) begin
         check("grant_timeout", 32'd0, 32'd1);
         p_valid = 2'b00;
         return;
      end
      e.port_oh = (port == 0) ? 2'b01 : 2'b10;
      e.err     = exp_err;
      e.rdata   = exp_rdata;
      e.acc_cyc = cyc;
      rq.push_back(e);
      if (we && !exp_err) begin
         w.addr = addr[AW+1:2];
         w.data = exp_wdata;
         wq.push_back(w);
      end
      @(posedge clk);
      #1 p_valid[port] = 1'b0;
      @(negedge clk);
      if (!exp_err) check("access_mem_addr", {22'd0, mem_addr}, {22'd0, addr[AW+1:2]});
      drain();
   endtask

   // Holds p_valid at vmask and checks p_ready every cycle: a grant every
   // third cycle, alternating ports when both request.
   task automatic hold(input logic [1:0] vmask, input int ngr, input logic first,
                       input logic [31:0] exp0, input logic [31:0] exp1);
      logic       g;
      logic [1:0] exp_rdy;
      rsp_t       e;
      g = first;
      @(negedge clk);
      p_valid = vmask;
      for (int c = 0; c < 3 * ngr; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         exp_rdy = (c % 3 == 0) ? (g ? 2'b10 : 2'b01) : 2'b00;
         check($sformatf("hold_p_ready_c%0d", c), {30'd0, p_ready}, {30'd0, exp_rdy});
         if (c % 3 == 0) begin
            e.port_oh = exp_rdy;
            e.err     = 1'b0;
            e.rdata   = g ? exp1 : exp0;
            e.acc_cyc = cyc;
            rq.push_back(e);
            if (vmask == 2'b11) g = ~g;
         end
      end
      @(negedge clk);
      p_valid = 2'b00;
      drain();
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
      mem[5] = 32'h5566_7788;

      rst        = 1'b0;
      p_valid    = 2'b00;
      p_we       = 2'b00;
      p_size0    = 2'b00;
      p_size1    = 2'b00;
      p_unsigned = 2'b00;
      p_addr0    = 32'd0;
      p_addr1    = 32'd0;
      p_wdata0   = 32'd0;
      p_wdata1   = 32'd0;

      // Reset state
      #1;
      check("rst_p_ready",     {30'd0, p_ready}, 32'd0);
      check("rst_r_valid",     {30'd0, r_valid}, 32'd0);
      check("rst_r_err",       {31'd0, r_err},   32'd0);
      check("rst_r_rdata",     r_rdata,          32'd0);
      check("rst_mem_wr_en",   {31'd0, mem_wr_en}, 32'd0);
      check("rst_mem_addr",    {22'd0, mem_addr},  32'd0);
      check("rst_mem_wr_data", mem_wr_data,      32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Both ports from reset: 0,1,0,1
      set_req(0, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
      set_req(1, 1'b0, 2'b01, 1'b1, 32'h16, 32'd0);
      hold(2'b11, 4, 1'b0, 32'h5566_7788, 32'h0000_5566);

      // Port 0 back-to-back: ready at 0,3,6
      set_req(0, 1'b0, 2'b00, 1'b0, 32'h14, 32'd0);
      hold(2'b01, 3, 1'b0, 32'hFFFF_FF88, 32'd0);

      // Port 1 alone
      set_req(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
      hold(2'b10, 2, 1'b1, 32'd0, 32'h5566_7788);

      // Word store / load
      issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0,          32'hDEAD_BEEF);
      issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0,        1'b0, 32'hDEAD_BEEF, 32'd0);

      // Sub-word read-modify-write
      issue(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'd0,        32'h1122_3344);
      issue(0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_56AA, 1'b0, 32'd0,        32'h11AA_3344);
      issue(0, 1'b0, 2'b00, 1'b0, 32'h12, 32'd0,         1'b0, 32'hFFFF_FFAA, 32'd0);
      issue(1, 1'b0, 2'b00, 1'b1, 32'h12, 32'd0,         1'b0, 32'h0000_00AA, 32'd0);
      issue(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0,         1'b0, 32'h0000_11AA, 32'd0);
      issue(1, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_BEEF, 1'b0, 32'd0,        32'hBEEF_3344);
      issue(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0,         1'b0, 32'hFFFF_BEEF, 32'd0);
      issue(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0,         1'b0, 32'hFFFF_FFBE, 32'd0);

      // Errors: no write, r_rdata cleared, response on the requesting port
      issue(0, 1'b0, 2'b01, 1'b0, 32'h13,   32'd0,        1'b1, 32'd0, 32'd0);
      issue(1, 1'b1, 2'b10, 1'b0, 32'h16,   32'h9999_9999, 1'b1, 32'd0, 32'd0);
      issue(0, 1'b0, 2'b11, 1'b0, 32'h10,   32'd0,        1'b1, 32'd0, 32'd0);
      issue(1, 1'b1, 2'b00, 1'b0, 32'h1000, 32'h77,       1'b1, 32'd0, 32'd0);
      issue(0, 1'b0, 2'b10, 1'b0, 32'h10,   32'd0,        1'b0, 32'hBEEF_3344, 32'd0);

      // Reset during a store ACCESS
      @(negedge clk);
      set_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D);
      p_valid[0] = 1'b1;
      #1 check("rstcase_grant", {30'd0, p_ready}, 32'd1);
      @(posedge clk);
      #1 p_valid = 2'b00;
      check("rstcase_wr_en_before", {31'd0, mem_wr_en}, 32'd1);
      #1 rst = 1'b0;
      #1 check("rstcase_wr_en_after", {31'd0, mem_wr_en}, 32'd0);
      check("rstcase_r_valid", {30'd0, r_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (4) @(negedge clk);
      set_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
      set_req(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0);
      hold(2'b11, 2, 1'b0, 32'hBEEF_3344, 32'h5566_7788);

      check("final_rq_empty", rq.size(), 32'd0);
      check("final_wq_empty", wq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
